// File: rtl/icmp_rx.sv
// icmp_rx -- receive-side ICMP Echo Request parser.
//
// Consumes the ICMP bytes of an IPv4 datagram after the IP header stage has
// announced it with ip_header_rx_done. It checks type (8'h08), code (8'h00)
// and, optionally, the ones-complement checksum. On success it publishes the
// identifier and sequence number with a one-cycle icmp_request_done pulse.
// A rejected message gives a one-cycle icmp_error pulse instead.
//
// Optional feature macro: ICMP_RX_CHECKSUM_EN
//   defined   : the 32-bit checksum accumulator is built and the checksum
//               must fold to 16'hFFFF for a pass.
//   undefined : no accumulator; the checksum term is treated as true. The
//               FOLD/VERIFY states still run, so the latency is unchanged.
//
// Byte stream handshake: data_valid is a pure strobe with no back-pressure.
// data_in is taken on every clock edge where data_valid is high and the FSM
// is in a byte state. Strobes in IDLE, FOLD or VERIFY are ignored.
//
// Ports:
//   aclk, areset         clock, asynchronous active-high reset
//   ip_header_rx_done    start pulse; ip_payload_len sampled with it
//   ip_payload_len[15:0] ICMP message length in bytes
//   data_in[7:0]         ICMP byte, network order
//   data_valid           byte strobe
//   icmp_request_done    pulse: valid Echo Request parsed
//   icmp_id[15:0]        identifier of the last valid request
//   icmp_seq_num[15:0]   sequence number of the last valid request
//   icmp_error           pulse: message rejected
//   busy                 high whenever the FSM is not IDLE
//   dbg_state[3:0]       current FSM state, for observation only

module icmp_rx (
  input  logic        aclk,
  input  logic        areset,
  input  logic        ip_header_rx_done,
  input  logic [15:0] ip_payload_len,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        icmp_request_done,
  output logic [15:0] icmp_id,
  output logic [15:0] icmp_seq_num,
  output logic        icmp_error,
  output logic        busy,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_TYPE    = 4'd1,
    S_CODE    = 4'd2,
    S_CSUM_HI = 4'd3,
    S_CSUM_LO = 4'd4,
    S_ID_HI   = 4'd5,
    S_ID_LO   = 4'd6,
    S_SEQ_HI  = 4'd7,
    S_SEQ_LO  = 4'd8,
    S_PAYLOAD = 4'd9,
    S_FOLD    = 4'd10,
    S_VERIFY  = 4'd11
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        odd;
  logic        type_ok, code_ok;
  logic [15:0] id_sh, seq_sh;
  logic        byte_state, byte_acc, short_len, csum_ok, pass;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign short_len = (ip_payload_len < 16'd8);

  always_comb begin
    byte_state = 1'b0;
    case (state)
      S_TYPE, S_CODE, S_CSUM_HI, S_CSUM_LO, S_ID_HI, S_ID_LO,
      S_SEQ_HI, S_SEQ_LO, S_PAYLOAD: byte_state = 1'b1;
      default:                       byte_state = 1'b0;
    endcase
  end

  assign byte_acc = data_valid && byte_state;

`ifdef ICMP_RX_CHECKSUM_EN
  logic [31:0] sum;
  logic [16:0] sum_f;
  logic [15:0] sum_folded;

  // Even-offset bytes are the high half of a 16-bit word. A trailing odd
  // byte therefore lands as {b,8'h00}, which is the implicit zero pad.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sum <= 32'd0;
    end else if (ip_header_rx_done) begin
      sum <= 32'd0;
    end else if (byte_acc) begin
      sum <= sum + (odd ? {24'd0, data_in} : {16'd0, data_in, 8'd0});
    end else if (state == S_FOLD) begin
      sum <= {16'd0, sum[31:16]} + {16'd0, sum[15:0]};
    end
  end

  // Second fold plus end-around carry; a correct message sums to all ones.
  always_comb begin
    sum_f      = {1'b0, sum[31:16]} + {1'b0, sum[15:0]};
    sum_folded = sum_f[15:0] + {15'd0, sum_f[16]};
    csum_ok    = (sum_folded == 16'hFFFF);
  end
`else
  assign csum_ok = 1'b1;
`endif

  assign pass = type_ok && code_ok && csum_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    state_nxt = S_IDLE;
      S_TYPE:    if (data_valid) state_nxt = S_CODE;
      S_CODE:    if (data_valid) state_nxt = S_CSUM_HI;
      S_CSUM_HI: if (data_valid) state_nxt = S_CSUM_LO;
      S_CSUM_LO: if (data_valid) state_nxt = S_ID_HI;
      S_ID_HI:   if (data_valid) state_nxt = S_ID_LO;
      S_ID_LO:   if (data_valid) state_nxt = S_SEQ_HI;
      S_SEQ_HI:  if (data_valid) state_nxt = S_SEQ_LO;
      // cnt == 1 means the byte being accepted is the last one.
      S_SEQ_LO, S_PAYLOAD:
        if (data_valid) state_nxt = (cnt == 16'd1) ? S_FOLD : S_PAYLOAD;
      S_FOLD:    state_nxt = S_VERIFY;
      S_VERIFY:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    // A start pulse always wins, including a restart mid-message.
    if (ip_header_rx_done) state_nxt = short_len ? S_IDLE : S_TYPE;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state             <= S_IDLE;
      cnt               <= 16'd0;
      odd               <= 1'b0;
      type_ok           <= 1'b0;
      code_ok           <= 1'b0;
      id_sh             <= 16'd0;
      seq_sh            <= 16'd0;
      icmp_request_done <= 1'b0;
      icmp_error        <= 1'b0;
      icmp_id           <= 16'd0;
      icmp_seq_num      <= 16'd0;
    end else begin
      state             <= state_nxt;
      icmp_request_done <= 1'b0;
      icmp_error        <= 1'b0;
      if (ip_header_rx_done) begin
        cnt     <= ip_payload_len;
        odd     <= 1'b0;
        type_ok <= 1'b0;
        code_ok <= 1'b0;
        id_sh   <= 16'd0;
        seq_sh  <= 16'd0;
        if (short_len) icmp_error <= 1'b1;
      end else if (byte_acc) begin
        cnt <= cnt - 16'd1;
        odd <= ~odd;
        case (state)
          S_TYPE:   type_ok      <= (data_in == 8'h08);
          S_CODE:   code_ok      <= (data_in == 8'h00);
          S_ID_HI:  id_sh[15:8]  <= data_in;
          S_ID_LO:  id_sh[7:0]   <= data_in;
          S_SEQ_HI: seq_sh[15:8] <= data_in;
          S_SEQ_LO: seq_sh[7:0]  <= data_in;
          default:  ;
        endcase
      end else if (state == S_VERIFY) begin
        if (pass) begin
          icmp_request_done <= 1'b1;
          icmp_id           <= id_sh;
          icmp_seq_num      <= seq_sh;
        end else begin
          icmp_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/icmp_rx.md
# icmp_rx

Receive-side ICMP parser for the Ethernet/IP stack. It sits between the IP header receive stage and `icmp_tx`. It consumes the ICMP bytes of an IPv4 datagram and checks that the message is an Echo Request with a valid checksum. On success it hands the identifier and sequence number to `icmp_tx` through a one-cycle `icmp_request_done` pulse.

## Interface
Parameters:
- none

Ports:
- `aclk` in 1: single clock domain.
- `areset` in 1: asynchronous, active-high reset.
- `ip_header_rx_done` in 1: one-cycle pulse. The IPv4 header is complete, protocol = 1 (ICMP), and `ip_payload_len` is valid.
- `ip_payload_len` in 16: ICMP message length in bytes (IP total length minus IHL×4). Sampled on `ip_header_rx_done`.
- `data_in` in 8: ICMP byte stream, MSB-first network order.
- `data_valid` in 1: byte strobe. `data_in` is accepted on each clock where it is high.
- `icmp_request_done` out 1: one-cycle pulse for a valid Echo Request.
- `icmp_id` out 16: identifier from the last valid request.
- `icmp_seq_num` out 16: sequence number from the last valid request.
- `icmp_error` out 1: one-cycle pulse for a rejected message.
- `busy` out 1: high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE → TYPE on `ip_header_rx_done`.
  - TYPE → CODE → CSUM (2 bytes) → ID (2 bytes) → SEQ (2 bytes) → PAYLOAD (remaining bytes).
  - After the final byte the FSM goes to FOLD, then VERIFY, then IDLE.
  - Advancing through byte states needs an accepted byte (`data_valid`=1). Gaps in `data_valid` hold the state.
- 16-bit remaining-byte counter:
  - Loaded with `ip_payload_len` on start.
  - Decrements on each accepted byte.
  - Byte 8 onward goes to PAYLOAD. When the counter reaches 0 after SEQ, the FSM goes straight to FOLD.
- Capture: type and code go to flags. ID and SEQ go into shadow registers. Payload bytes are discarded.
- Checksum accumulator:
  - 32 bits, cleared on start.
  - Even-offset byte b adds {b,8'h00`}; odd-offset byte adds {8'h00,b}. Checksum bytes are included.
  - An odd-length message is implicitly zero-padded.
  - FOLD: sum ← sum[31:16] + sum[15:0].
  - VERIFY: f = sum[31:16] + sum[15:0] (17-bit); folded = f[15:0] + f[16]. The check passes iff folded == 16'hFFFF.
- VERIFY decision:
  - Pass = type == 8'h08 AND code == 8'h00 AND checksum check. On pass, the shadow ID and SEQ are copied to `icmp_id`/`icmp_seq_num` and `icmp_request_done` pulses.
  - Otherwise `icmp_error` pulses and the outputs hold their old values.
- Short length: if `ip_payload_len` < 8 at start, `icmp_error` pulses on the next cycle, the FSM stays in IDLE, and the bytes are ignored.
- Restart: `ip_header_rx_done` while not IDLE discards the current message with no pulse and restarts at TYPE with the new length.
- `data_valid` in IDLE is ignored.

## Timing
- Reset values: all outputs 0, FSM = IDLE, accumulator, counter and shadows = 0.
- Reset mid-message aborts immediately with no pulse.
- First byte may be accepted in the cycle after the `ip_header_rx_done` pulse, or later.
- Latency: last byte accepted at edge k. FOLD executes at edge k+1. VERIFY registers the result at edge k+2. The `icmp_request_done`/`icmp_error` pulse is high between edges k+2 and k+3.
- `icmp_id`/`icmp_seq_num` change at the same edge as `icmp_request_done` rises and are stable while it is high.
- `busy` falls at edge k+2.
- `ip_header_rx_done` is accepted in the cycle the FSM returns to IDLE.

## Configuration
- `ICMP_RX_CHECKSUM_EN` defined: the checksum check applies as described.
- Undefined: the accumulator is removed and the checksum term of Pass is forced true. FOLD/VERIFY still run, so latency is identical.

## Test plan
- Valid request, len=8, bytes 08 00 E5 CA 12 34 00 01 -> `icmp_request_done` pulse at k+2, `icmp_id`=0x1234, `icmp_seq_num`=0x0001, no `icmp_error`.
- Odd length, len=9, bytes 08 00 3A CA 12 34 00 01 AB, with `data_valid` low for 3 cycles between bytes 4 and 5 -> done pulse, id 0x1234, seq 0x0001.
- Corrupted checksum 08 00 E5 CB 12 34 00 01 -> with the macro: `icmp_error` pulse and id/seq unchanged. Without the macro: `icmp_request_done` pulse.
- Echo Reply, bytes 00 00 ED CA 12 34 00 01 -> `icmp_error` pulse and no done pulse.
- len=6 -> `icmp_error` one cycle after start, `busy` stays 0, and a following valid request parses correctly.
- `areset` asserted after byte 5, then a valid request with id 0xBEEF, seq 0x0002 -> exactly one done pulse, with id 0xBEEF and seq 0x0002. A new `ip_header_rx_done` mid-message restarts cleanly with no stray pulse.
